// File: rtl/serdes_word_aligner.sv
// -----------------------------------------------------------------------------
// serdes_word_aligner
//
// Receive front end for an 8b/10b link. It shifts in one line bit per enabled
// clock, hunts for the K28.5 comma (either running disparity) to find the
// 10-bit symbol boundary, and then emits aligned symbols to the decoder. The
// decoder's invalid-symbol flag comes back on err_in. ERR_MAX consecutive
// flagged symbols drop lock and restart the hunt.
//
// Ports
//   clk         rising-edge clock, one serial bit per enabled cycle
//   rst         asynchronous, active-low reset
//   enb         bit enable; 0 stalls everything and suppresses all pulses
//   serial_in   line bit; the first bit of a symbol lands in data10_out[9]
//   err_in      decoder invalid flag, one cycle after the decoder sees a word
//   data10_out  aligned 10-bit symbol (to decoder data10_in)
//   valid_out   pulse: data10_out was updated this cycle
//   comma_det   pulse: the word just emitted is a comma
//   realign     pulse: a comma moved the boundary while locked
//   locked      high while symbol alignment is established
// -----------------------------------------------------------------------------
module serdes_word_aligner #(
  parameter int unsigned ERR_MAX = 4,
  parameter logic [9:0]  COMMA_P = 10'b0011111010,
  parameter logic [9:0]  COMMA_N = 10'b1100000101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       serial_in,
  input  logic       err_in,
  output logic [9:0] data10_out,
  output logic       valid_out,
  output logic       comma_det,
  output logic       realign,
  output logic       locked
);

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  localparam logic [3:0] ERR_MAX_C  = 4'(ERR_MAX);
  localparam logic [3:0] LAST_BIT   = 4'd9;

  state_t     state_q,   state_d;
  logic [8:0] sr_q,      sr_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [9:0] data_q,    data_d;
  logic       valid_q,   valid_d;
  logic       comma_q,   comma_d;
  logic       realign_q, realign_d;
  logic       err_win_q, err_win_d;

  // Candidate symbol including the bit being sampled on this edge; every
  // comparison looks at it so a word is registered on its 10th-bit edge.
  logic [9:0] nxt;
  logic       is_comma;
  logic       at_boundary;
  logic       err_sample;
  logic [3:0] err_inc;
  logic       err_trip;

  assign nxt         = {sr_q, serial_in};
  assign is_comma    = (nxt == COMMA_P) || (nxt == COMMA_N);
  assign at_boundary = (bit_cnt_q == LAST_BIT);

  // The decoder registers the word for one cycle, so its verdict on a word is
  // on err_in during the cycle after valid_out. err_win_q marks that cycle.
  assign err_sample  = err_win_q && enb && (state_q == SYNC);
  assign err_inc     = (err_cnt_q == 4'hF) ? 4'hF : err_cnt_q + 4'd1;
  // A comma on the same edge wins over an error count.
  assign err_trip    = err_sample && err_in && !is_comma && (err_inc == ERR_MAX_C);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every flop here has a defined reset value, so a partial symbol and
  // any pending error window are discarded the instant rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      comma_q   <= 1'b0;
      realign_q <= 1'b0;
      err_win_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      comma_q   <= comma_d;
      realign_q <= realign_d;
      err_win_q <= err_win_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (enb) begin
      unique case (state_q)
        HUNT: if (is_comma) state_d = SYNC;
        SYNC: if (err_trip) state_d = HUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first (hold or idle) so no path leaves a signal unassigned
    // and no latch is inferred.
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    comma_d   = 1'b0;
    realign_d = 1'b0;
    err_win_d = valid_q;

    if (enb) begin
      sr_d = nxt[8:0];
      unique case (state_q)
        HUNT: begin
          if (is_comma) begin
            data_d    = nxt;
            valid_d   = 1'b1;
            comma_d   = 1'b1;
            bit_cnt_d = '0;
            err_cnt_d = '0;
          end
        end
        SYNC: begin
          if (is_comma) begin
            // A comma always defines the boundary; off-boundary means slip.
            data_d    = nxt;
            valid_d   = 1'b1;
            comma_d   = 1'b1;
            realign_d = !at_boundary;
            bit_cnt_d = '0;
            err_cnt_d = '0;
          end else begin
            if (at_boundary) begin
              data_d    = nxt;
              valid_d   = 1'b1;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
            if (err_sample) begin
              if (!err_in) begin
                err_cnt_d = '0;
              end else if (err_trip) begin
                // Lock lost: a word emitted on this same edge still goes out.
                err_cnt_d = '0;
                bit_cnt_d = '0;
              end else begin
                err_cnt_d = err_inc;
              end
            end
          end
        end
      endcase
    end
  end

  assign data10_out = data_q;
  assign valid_out  = valid_q;
  assign comma_det  = comma_q;
  assign realign    = realign_q;
  assign locked     = (state_q == SYNC);

endmodule

// File: tb/tb_serdes_word_aligner.sv
// -----------------------------------------------------------------------------
// tb_serdes_word_aligner
//
// Drives serial bit streams into serdes_word_aligner and compares every cycle
// against a behavioural model that keeps the last ten received bits in a
// queue, counts bits since the last emitted word, and remembers on which clock
// edges words were emitted so it knows when decoder feedback counts.
// -----------------------------------------------------------------------------
module tb_serdes_word_aligner;

  localparam int         ERR_MAX = 4;
  localparam logic [9:0] K_P     = 10'b0011111010;
  localparam logic [9:0] K_N     = 10'b1100000101;
  localparam logic [9:0] D_W     = 10'b1011011101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b0;
  logic       serial_in = 1'b0;
  logic       err_in = 1'b0;
  logic [9:0] data10_out;
  logic       valid_out;
  logic       comma_det;
  logic       realign;
  logic       locked;

  serdes_word_aligner #(
    .ERR_MAX (ERR_MAX),
    .COMMA_P (K_P),
    .COMMA_N (K_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .serial_in  (serial_in),
    .err_in     (err_in),
    .data10_out (data10_out),
    .valid_out  (valid_out),
    .comma_det  (comma_det),
    .realign    (realign),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit         m_hist[$];
  bit         m_locked;
  int         m_since;
  int         m_errs;
  logic [9:0] m_data;
  bit         m_valid, m_cd, m_rl;
  int         edge_n;
  bit         emit_log[int];

  // Error-injection controls used by tick.
  bit         err_rand   = 1'b0;
  int         err_budget = 0;

  function automatic void model_reset();
    m_hist = {};
    for (int i = 0; i < 10; i++) m_hist.push_back(1'b0);
    m_locked = 1'b0;
    m_since  = 0;
    m_errs   = 0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_cd     = 1'b0;
    m_rl     = 1'b0;
    emit_log.delete();
  endfunction

  function automatic logic [9:0] window();
    int w = 0;
    foreach (m_hist[i]) w = (w << 1) | int'(m_hist[i]);
    return w[9:0];
  endfunction

  function automatic void emit(input logic [9:0] w);
    m_data  = w;
    m_valid = 1'b1;
    emit_log[edge_n] = 1'b1;
  endfunction

  function automatic void model_step(input bit b, input bit en, input bit e);
    logic [9:0] w;
    bit         comma;
    bit         sample;
    bit         boundary;
    edge_n++;
    m_valid = 1'b0;
    m_cd    = 1'b0;
    m_rl    = 1'b0;
    if (!en) return;
    sample = m_locked && emit_log.exists(edge_n - 2);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
    w     = window();
    comma = (w == K_P) || (w == K_N);
    if (!m_locked) begin
      if (comma) begin
        emit(w);
        m_cd     = 1'b1;
        m_locked = 1'b1;
        m_since  = 0;
        m_errs   = 0;
      end
    end else begin
      boundary = (m_since + 1 == 10);
      if (comma) begin
        emit(w);
        m_cd    = 1'b1;
        m_rl    = !boundary;
        m_since = 0;
        m_errs  = 0;
      end else begin
        if (boundary) begin
          emit(w);
          m_since = 0;
        end else begin
          m_since++;
        end
        if (sample) begin
          if (e) begin
            m_errs++;
            if (m_errs == ERR_MAX) begin
              m_locked = 1'b0;
              m_since  = 0;
              m_errs   = 0;
            end
          end else begin
            m_errs = 0;
          end
        end
      end
    end
  endfunction

  function automatic logic [13:0] dut_vec();
    return {valid_out, comma_det, realign, locked, data10_out};
  endfunction

  function automatic logic [13:0] exp_vec();
    return {m_valid, m_cd, m_rl, m_locked, m_data};
  endfunction

  // One clock: drive inputs, take the edge, advance the model, settle.
  // err_in is random noise except in the decoder-feedback cycle.
  task automatic tick(input bit b, input bit en);
    bit e;
    if (emit_log.exists(edge_n - 1)) begin
      if (err_rand) begin
        e = 1'($urandom_range(0, 1));
      end else if (err_budget > 0) begin
        e = 1'b1;
        err_budget--;
      end else begin
        e = 1'b0;
      end
    end else begin
      e = 1'($urandom_range(0, 1));
    end
    serial_in = b;
    enb       = en;
    err_in    = e;
    @(posedge clk);
    model_step(b, en, e);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    #1;
    tests_run++;
    if (dut_vec() !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got %b want %b", dut_vec(), 14'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (dut_vec() !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_held: got %b want %b", dut_vec(), 14'd0);
    end
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_acquire();
    logic [9:0] w;
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL acquire_prefix: got %b want %b", dut_vec(), exp_vec());
      end
    end
    w = K_P;
    for (int i = 9; i >= 0; i--) begin
      tick(w[i], 1'b1);
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL acquire_comma_bit: got %b want %b", dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if ({valid_out, comma_det, locked, data10_out} !== {3'b111, K_P}) begin
      tests_failed++;
      $display("FAIL acquire_lock: got %b want %b",
               {valid_out, comma_det, locked, data10_out}, {3'b111, K_P});
    end
    w = D_W;
    for (int k = 0; k < 3; k++) begin
      for (int i = 9; i >= 0; i--) begin
        tick(w[i], 1'b1);
        tests_run++;
        if (valid_out !== (i == 0) || dut_vec() !== exp_vec()) begin
          tests_failed++;
          $display("FAIL acquire_dword_spacing: got %b want %b", dut_vec(), exp_vec());
        end
      end
      tests_run++;
      if ({comma_det, data10_out} !== {1'b0, D_W}) begin
        tests_failed++;
        $display("FAIL acquire_dword: got %b want %b", {comma_det, data10_out}, {1'b0, D_W});
      end
    end
  endtask

  task automatic test_rd_plus_comma();
    logic [9:0] w;
    w = K_N;
    for (int i = 9; i >= 0; i--) begin
      tick(w[i], 1'b1);
      tests_run++;
      if (valid_out !== (i == 0) || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL rdp_comma_bit: got %b want %b", dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if ({comma_det, realign, data10_out} !== {2'b10, K_N}) begin
      tests_failed++;
      $display("FAIL rdp_comma: got %b want %b", {comma_det, realign, data10_out}, {2'b10, K_N});
    end
    w = D_W;
    for (int i = 9; i >= 0; i--) begin
      tick(w[i], 1'b1);
      tests_run++;
      if (valid_out !== (i == 0) || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL rdp_spacing: got %b want %b", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_off_boundary();
    logic [9:0] w;
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL slip_bits: got %b want %b", dut_vec(), exp_vec());
      end
    end
    w = K_P;
    for (int i = 9; i >= 0; i--) begin
      tick(w[i], 1'b1);
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL slip_comma_bit: got %b want %b", dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if ({valid_out, comma_det, realign, locked, data10_out} !== {4'b1111, K_P}) begin
      tests_failed++;
      $display("FAIL slip_realign: got %b want %b",
               {valid_out, comma_det, realign, locked, data10_out}, {4'b1111, K_P});
    end
    w = D_W;
    for (int k = 0; k < 2; k++) begin
      for (int i = 9; i >= 0; i--) begin
        tick(w[i], 1'b1);
        tests_run++;
        if (valid_out !== (i == 0) || dut_vec() !== exp_vec()) begin
          tests_failed++;
          $display("FAIL slip_new_boundary: got %b want %b", dut_vec(), exp_vec());
        end
      end
      tests_run++;
      if (data10_out !== D_W) begin
        tests_failed++;
        $display("FAIL slip_word: got %b want %b", data10_out, D_W);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    logic [9:0] w;
    int         valids;
    w = D_W;
    // Three flagged words, then a clean one: lock must survive.
    err_budget = 3;
    for (int k = 0; k < 5; k++) begin
      for (int i = 9; i >= 0; i--) begin
        tick(w[i], 1'b1);
        tests_run++;
        if (dut_vec() !== exp_vec()) begin
          tests_failed++;
          $display("FAIL err3_stream: got %b want %b", dut_vec(), exp_vec());
        end
      end
    end
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL err3_keeps_lock: got %b want %b", locked, 1'b1);
    end
    // Four flagged words: lock drops on the fourth feedback sample.
    err_budget = 4;
    valids     = 0;
    for (int k = 0; k < 7; k++) begin
      for (int i = 9; i >= 0; i--) begin
        tick(w[i], 1'b1);
        if (k >= 4 && valid_out === 1'b1) valids++;
        tests_run++;
        if (dut_vec() !== exp_vec()) begin
          tests_failed++;
          $display("FAIL err4_stream: got %b want %b", dut_vec(), exp_vec());
        end
      end
    end
    tests_run++;
    if ({locked, valids[3:0]} !== 5'd0) begin
      tests_failed++;
      $display("FAIL err4_lost_lock: got locked=%b valids=%0d want locked=0 valids=0",
               locked, valids);
    end
    w = K_P;
    for (int i = 9; i >= 0; i--) begin
      tick(w[i], 1'b1);
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL relock_bit: got %b want %b", dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if ({valid_out, comma_det, locked} !== 3'b111) begin
      tests_failed++;
      $display("FAIL relock: got %b want %b", {valid_out, comma_det, locked}, 3'b111);
    end
  endtask

  task automatic test_enb_stall();
    logic [9:0] w;
    logic [9:0] held;
    w    = D_W;
    held = data10_out;
    for (int i = 9; i >= 6; i--) begin
      tick(w[i], 1'b1);
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL stall_pre: got %b want %b", dut_vec(), exp_vec());
      end
    end
    for (int c = 0; c < 7; c++) begin
      tick(1'($urandom_range(0, 1)), 1'b0);
      tests_run++;
      if ({valid_out, comma_det, realign, locked, data10_out} !== {4'b0001, held}
          || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL stall_hold: got %b want %b",
                 {valid_out, comma_det, realign, locked, data10_out}, {4'b0001, held});
      end
    end
    for (int i = 5; i >= 0; i--) begin
      tick(w[i], 1'b1);
      tests_run++;
      if (valid_out !== (i == 0) || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL stall_resume: got %b want %b", dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (data10_out !== D_W) begin
      tests_failed++;
      $display("FAIL stall_word: got %b want %b", data10_out, D_W);
    end
  endtask

  task automatic test_random_stream();
    bit pend[$];
    bit b;
    bit en;
    logic [9:0] c;
    err_rand = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (pend.size() == 0 && $urandom_range(0, 29) == 0) begin
        c = ($urandom_range(0, 1) == 0) ? K_P : K_N;
        for (int i = 9; i >= 0; i--) pend.push_back(c[i]);
      end
      en = ($urandom_range(0, 7) != 0);
      if (en && pend.size() > 0) b = pend.pop_front();
      else                       b = 1'($urandom_range(0, 1));
      tick(b, en);
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_stream cycle %0d: got %b want %b", n, dut_vec(), exp_vec());
      end
    end
    err_rand = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [9:0] w;
    int         guard;
    w = K_P;
    for (int i = 9; i >= 0; i--) tick(w[i], 1'b1);
    tests_run++;
    if ({locked, data10_out} !== {1'b1, K_P} || dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL midrst_lock: got %b want %b", dut_vec(), exp_vec());
    end
    w     = D_W;
    guard = 9;
    while (m_since != 5 && guard >= 0) begin
      tick(w[guard], 1'b1);
      guard--;
    end
    tests_run++;
    if (m_since != 5) begin
      tests_failed++;
      $display("FAIL midrst_position: got %0d want 5", m_since);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (dut_vec() !== 14'd0) begin
      tests_failed++;
      $display("FAIL midrst_async_clear: got %b want %b", dut_vec(), 14'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL midrst_idle: got %b want %b", dut_vec(), exp_vec());
      end
    end
    w = K_P;
    for (int i = 9; i >= 0; i--) tick(w[i], 1'b1);
    tests_run++;
    if ({valid_out, comma_det, locked, data10_out} !== {3'b111, K_P}) begin
      tests_failed++;
      $display("FAIL midrst_reacquire: got %b want %b",
               {valid_out, comma_det, locked, data10_out}, {3'b111, K_P});
    end
    w = D_W;
    for (int i = 9; i >= 0; i--) begin
      tick(w[i], 1'b1);
      tests_run++;
      if (valid_out !== (i == 0) || dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL midrst_word: got %b want %b", dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    edge_n = 0;
    model_reset();
    test_reset();
    test_acquire();
    test_rd_plus_comma();
    test_off_boundary();
    test_loss_of_lock();
    test_enb_stall();
    test_random_stream();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got no end want end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serdes_word_aligner.md
Name: serdes_word_aligner

Overview:
- Serial-to-parallel receive front end that sits directly upstream of the 8b/10b decoder.
- Shifts in one line bit per clock and hunts for the K28.5 comma to find 10-bit symbol boundaries.
- Once locked, emits aligned 10-bit words to the decoder's data10_in.
- Drops lock after repeated decode errors reported back by the decoder.

Parameters:
- ERR_MAX, 4: consecutive decoder-flagged invalid words that force loss of lock (range 1..15).
- COMMA_P, 10'b0011111010: K28.5 pattern, RD-, bit 9 is first bit received ('a').
- COMMA_N, 10'b1100000101: K28.5 pattern, RD+.

Ports:
- clk  input  1  rising-edge clock, one serial bit per cycle.
- rst  input  1  asynchronous, active-low reset.
- enb  input  1  bit-enable; 0 = stall (no shift, no count, no outputs pulse).
- serial_in  input  1  line bit; first received bit of a symbol ends up in data10_out[9].
- err_in  input  1  decoder invalid_value feedback.
- data10_out  output  10  aligned symbol, to decoder data10_in.
- valid_out  output  1  one-cycle pulse: data10_out updated this cycle.
- comma_det  output  1  one-cycle pulse: the emitted word is a comma.
- realign  output  1  one-cycle pulse: boundary moved while locked.
- locked  output  1  1 while in SYNC state.

Behaviour:
- Reset (rst=0, async): shift reg=0, bit_cnt=0, err_cnt=0, state=HUNT, data10_out=0, valid_out=0, comma_det=0, realign=0, locked=0.
- Next-shift value: nxt = {sr[8:0], serial_in}. All compares are done on nxt. sr<=nxt on every edge with enb=1.
- is_comma = (nxt==COMMA_P) || (nxt==COMMA_N).
- Zero latency: the word is registered on the same edge that samples its 10th bit.
- enb=0:
  - sr, bit_cnt, err_cnt and state hold.
  - All pulses are 0.
  - data10_out and locked hold.
- State HUNT (locked=0):
  - No word output while no comma is found.
  - On is_comma: data10_out<=nxt, valid_out=1, comma_det=1, bit_cnt<=0, err_cnt<=0, go SYNC. realign stays 0.
- State SYNC (locked=1):
  - bit_cnt counts 0..9 and wraps.
  - At bit_cnt==9: data10_out<=nxt, valid_out=1, comma_det=is_comma, bit_cnt<=0.
  - On is_comma with bit_cnt!=9 (off-boundary comma):
    - data10_out<=nxt, valid_out=1, comma_det=1, realign=1, bit_cnt<=0.
    - err_cnt<=0; stay SYNC.
- Error tracking:
  - err_in is sampled only on the cycle immediately after a valid_out pulse (the decoder's registered latency). err_in is ignored otherwise.
  - Sampled 1: err_cnt+1, saturating.
  - Sampled 0: err_cnt<=0.
  - When the increment makes err_cnt==ERR_MAX: go HUNT, locked<=0, bit_cnt<=0, err_cnt<=0 on that edge.
- Simultaneous events:
  - err_in sample coinciding with a comma: the comma handling wins. err_cnt<=0, stay/go SYNC.
  - Err-driven loss of lock and a boundary word on the same edge: the word is still emitted (valid_out=1), then state=HUNT.
- Reset mid-word: all state is cleared immediately. The partially shifted symbol is discarded and a new comma is required.
- Widths:
  - bit_cnt: 4 bits, values 10..15 are unreachable.
  - err_cnt: 4 bits.

Test Plan:
- Reset and acquire: rst=0 for 2 cycles, then rst=1, enb=1. Send 3 random bits, then 0011111010, then 1011011101 (D-code) ×3.
  - After the comma's 10th bit: valid_out=1, comma_det=1, locked=1, data10_out=0011111010.
  - Then every 10 cycles: valid_out=1, data10_out=1011011101, comma_det=0.
- Locked stream with RD+ comma: send 1100000101 at a boundary. comma_det=1, realign=0, spacing of valid_out stays 10 cycles.
- Off-boundary comma: while locked, slip the stream by 3 bits then send 0011111010.
  - valid_out and realign pulse on that comma's last bit.
  - The following words are correct at the new boundary.
- Loss of lock: while locked, drive err_in=1 on the cycle after each of 4 consecutive valid_out pulses.
  - 4th sample drops locked to 0.
  - No valid_out until the next comma.
  - 3 errors followed by a clean word must keep lock.
- enb stall: deassert enb for 7 cycles mid-symbol.
  - No pulses during the stall; data10_out held.
  - After re-enable, the next word completes exactly at the original bit position.
- Reset mid-operation: assert rst asynchronously (between clock edges) while locked at bit_cnt=5.
  - Outputs clear immediately; locked=0.
  - A fresh comma re-acquires lock.
